// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB first under a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum, fa_carry;
  logic             accept, last_bit;

  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  // Sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign res_nxt  = (res_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1, so the carry flop supplies the +1.
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      carry  <= fa_carry;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        // On the MSB cycle the carry flop holds the carry into the sign bit.
        sum  <= res_nxt;
        cout <= fa_carry;
        ovf  <= carry ^ fa_carry;
      end
    end
  end

endmodule
